// File: rtl/vga_pll_lock_sequencer.sv
`timescale 1ns/1ps
// vga_pll_lock_sequencer
// Drives the VGA PLL reset, waits for lock, qualifies lock stability and only
// then releases the VGA clock-domain reset. Lock loss restarts the sequence;
// MAX_RETRIES consecutive failed attempts park the block in FAIL until restart.
// Optional feature macro: VGA_PLL_LOSS_CNT_EN adds an 8-bit saturating
// count of lock losses seen while running (loss_cnt).
module vga_pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             pll_locked,
  input  logic                             restart,
  output logic                             pll_rst,
  output logic                             vga_rst_n,
  output logic                             fail,
  output logic [2:0]                       state,
`ifdef VGA_PLL_LOSS_CNT_EN
  output logic [7:0]                       loss_cnt,
`endif
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);
  localparam int unsigned CMAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CMAX    = (CMAX_A > STABLE_CYCLES) ? CMAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LAST = RW'(MAX_RETRIES - 1);
  localparam logic [RW-1:0]    RETRY_SAT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_WAIT = 3'd1,
    S_STAB = 3'd2,
    S_RUN  = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   attempt_fail;
`ifdef VGA_PLL_LOSS_CNT_EN
  logic                   loss_evt;
  logic [7:0]             loss_q;
`endif

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign state     = state_q;
  assign retry_cnt = retry_q;
`ifdef VGA_PLL_LOSS_CNT_EN
  assign loss_cnt  = loss_q;
`endif

  // Bring the asynchronous PLL lock into the reference clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  // Next-state, counter and retry bookkeeping; restart overrides everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
`ifdef VGA_PLL_LOSS_CNT_EN
    loss_evt     = 1'b0;
`endif
    if (restart) begin
      state_d = S_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_d = S_STAB;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            attempt_fail = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STAB: begin
          if (!lock_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == STAB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_RST;
            cnt_d   = '0;
`ifdef VGA_PLL_LOSS_CNT_EN
            loss_evt = 1'b1;
`endif
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RST;
          cnt_d   = '0;
        end
      endcase
      // Both WAIT timeout and STAB lock drop funnel into one retry decision.
      if (attempt_fail) begin
        cnt_d = '0;
        if (retry_q == RETRY_LAST) begin
          state_d = S_FAIL;
          retry_d = RETRY_SAT;
        end else begin
          state_d = S_RST;
          retry_d = retry_q + RW'(1);
        end
      end
    end
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst   <= 1'b1;
      vga_rst_n <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst   <= (state_d == S_RST) || (state_d == S_FAIL);
      vga_rst_n <= (state_d == S_RUN);
      fail      <= (state_d == S_FAIL);
    end
  end

`ifdef VGA_PLL_LOSS_CNT_EN
  // Saturating count of lock losses while running; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        loss_q <= '0;
    else if (loss_evt && loss_q != '1)   loss_q <= loss_q + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_pll_lock_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for vga_pll_lock_sequencer with shortened timeouts.
module tb_vga_pll_lock_sequencer;

  localparam int unsigned R  = 16;
  localparam int unsigned T  = 300;
  localparam int unsigned S  = 64;
  localparam int unsigned M  = 3;
  localparam int unsigned N  = 2;
  localparam int unsigned RW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          restart;
  logic          pll_rst;
  logic          vga_rst_n;
  logic          fail;
  logic [2:0]    state;
  logic [RW-1:0] retry_cnt;
`ifdef VGA_PLL_LOSS_CNT_EN
  logic [7:0]    loss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_loss = 0;

  vga_pll_lock_sequencer #(
    .RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S),
    .MAX_RETRIES(M), .SYNC_STAGES(N)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .vga_rst_n(vga_rst_n), .fail(fail), .state(state),
`ifdef VGA_PLL_LOSS_CNT_EN
    .loss_cnt(loss_cnt),
`endif
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic measure_rst_pulse(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < int'(R) + 50) begin
      step();
      n++;
    end
  endtask

  // Release of pll_rst through RUN; lock rises d cycles into WAIT.
  task automatic test_lock_sequence(input int d);
    int n;
    int first_stab;
    measure_rst_pulse(n);
    total++; if (n != int'(R)) begin bad++; $display("FAIL rst_pulse: got %0d expected %0d", n, R); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL wait_entry: got %0d expected 1", state); end
    repeat (d) step();
    total++; if (state !== 3'd1 || vga_rst_n !== 1'b0) begin bad++; $display("FAIL wait_hold: got state=%0d vga=%0b expected 1/0", state, vga_rst_n); end
    pll_locked = 1'b1;
    n = 0; first_stab = -1;
    while (vga_rst_n !== 1'b1 && n < int'(N + S) + 20) begin
      step();
      n++;
      if (state === 3'd2 && first_stab < 0) first_stab = n;
    end
    total++; if (n != int'(N + S + 1)) begin bad++; $display("FAIL lock_to_run: got %0d expected %0d", n, N + S + 1); end
    total++; if (first_stab != int'(N + 1)) begin bad++; $display("FAIL lock_to_stab: got %0d expected %0d", first_stab, N + 1); end
    total++; if (state !== 3'd3 || pll_rst !== 1'b0 || retry_cnt !== '0 || fail !== 1'b0) begin
      bad++; $display("FAIL run_outputs: got state=%0d pll_rst=%0b retry=%0d fail=%0b expected 3/0/0/0", state, pll_rst, retry_cnt, fail);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (state !== 3'd0 || pll_rst !== 1'b1 || vga_rst_n !== 1'b0 || fail !== 1'b0 || retry_cnt !== '0) begin
      bad++; $display("FAIL reset_values: got state=%0d pll_rst=%0b vga=%0b fail=%0b retry=%0d expected 0/1/0/0/0", state, pll_rst, vga_rst_n, fail, retry_cnt);
    end
`ifdef VGA_PLL_LOSS_CNT_EN
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL reset_loss: got %0d expected 0", loss_cnt); end
`endif
    reset_n = 1'b1;
    exp_loss = 0;
  endtask

  task automatic test_timeout_fail;
    int n;
    pll_locked = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    total++; if (state !== 3'd0 || pll_rst !== 1'b1 || vga_rst_n !== 1'b0) begin
      bad++; $display("FAIL restart_from_run: got state=%0d pll_rst=%0b vga=%0b expected 0/1/0", state, pll_rst, vga_rst_n);
    end
    for (int k = 0; k < int'(M); k++) begin
      measure_rst_pulse(n);
      total++; if (n != int'(R)) begin bad++; $display("FAIL retry_pulse: got %0d expected %0d", n, R); end
      n = 0;
      while (state === 3'd1 && n < int'(T) + 20) begin step(); n++; end
      total++; if (n != int'(T)) begin bad++; $display("FAIL wait_length: got %0d expected %0d", n, T); end
      if (k < int'(M) - 1) begin
        total++; if (state !== 3'd0 || retry_cnt !== RW'(k + 1)) begin
          bad++; $display("FAIL timeout_retry: got state=%0d retry=%0d expected 0/%0d", state, retry_cnt, k + 1);
        end
      end
    end
    total++; if (state !== 3'd4 || fail !== 1'b1 || pll_rst !== 1'b1 || retry_cnt !== RW'(M) || vga_rst_n !== 1'b0) begin
      bad++; $display("FAIL fail_state: got state=%0d fail=%0b pll_rst=%0b retry=%0d vga=%0b expected 4/1/1/%0d/0", state, fail, pll_rst, retry_cnt, vga_rst_n, M);
    end
    repeat (40) begin
      pll_locked = 1'($urandom_range(0, 1));
      step();
    end
    pll_locked = 1'b0;
    repeat (N + 1) step();
    total++; if (state !== 3'd4 || fail !== 1'b1) begin bad++; $display("FAIL fail_sticky: got state=%0d fail=%0b expected 4/1", state, fail); end
  endtask

  task automatic test_restart;
    int n;
    restart = 1'b1;
    step();
    restart = 1'b0;
    total++; if (state !== 3'd0 || fail !== 1'b0 || retry_cnt !== '0 || pll_rst !== 1'b1) begin
      bad++; $display("FAIL restart_from_fail: got state=%0d fail=%0b retry=%0d pll_rst=%0b expected 0/0/0/1", state, fail, retry_cnt, pll_rst);
    end
    measure_rst_pulse(n);
    pll_locked = 1'b1;
    repeat (N + S) step();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL pre_run_stab: got %0d expected 2", state); end
    // restart lands on the edge that would otherwise enter RUN
    restart = 1'b1;
    pll_locked = 1'b0;
    step();
    restart = 1'b0;
    total++; if (state !== 3'd0 || vga_rst_n !== 1'b0 || retry_cnt !== '0 || pll_rst !== 1'b1) begin
      bad++; $display("FAIL restart_wins: got state=%0d vga=%0b retry=%0d pll_rst=%0b expected 0/0/0/1", state, vga_rst_n, retry_cnt, pll_rst);
    end
  endtask

  task automatic test_glitch;
    int n;
    int p;
    int g;
    bit vga_bad;
    measure_rst_pulse(n);
    total++; if (n != int'(R)) begin bad++; $display("FAIL glitch_pulse0: got %0d expected %0d", n, R); end
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < int'(N) + 10) begin step(); n++; end
    p = $urandom_range(1, S - 10);
    g = $urandom_range(1, 3);
    repeat (p) step();
    pll_locked = 1'b0;
    n = 0; vga_bad = 1'b0;
    while (state === 3'd2 && n < int'(N) + 10) begin
      step();
      n++;
      if (vga_rst_n !== 1'b0) vga_bad = 1'b1;
      if (n == g) pll_locked = 1'b1;
    end
    if (n < g) pll_locked = 1'b1;
    total++; if (n != int'(N + 1)) begin bad++; $display("FAIL glitch_latency: got %0d expected %0d", n, N + 1); end
    total++; if (state !== 3'd0 || retry_cnt !== RW'(1) || vga_bad || vga_rst_n !== 1'b0) begin
      bad++; $display("FAIL glitch_retry: got state=%0d retry=%0d vga=%0b expected 0/1/0", state, retry_cnt, vga_rst_n);
    end
    measure_rst_pulse(n);
    total++; if (n != int'(R)) begin bad++; $display("FAIL glitch_pulse1: got %0d expected %0d", n, R); end
    // lock already present when WAIT is entered
    n = 0;
    while (vga_rst_n !== 1'b1 && n < int'(S) + 20) begin step(); n++; end
    total++; if (n != int'(S + 1)) begin bad++; $display("FAIL relock_run: got %0d expected %0d", n, S + 1); end
    total++; if (state !== 3'd3 || retry_cnt !== '0) begin bad++; $display("FAIL relock_state: got state=%0d retry=%0d expected 3/0", state, retry_cnt); end
  endtask

  task automatic test_lock_loss(input int iters);
    int n;
    for (int i = 0; i < iters; i++) begin
      repeat ($urandom_range(1, 30)) step();
      pll_locked = 1'b0;
      n = 0;
      while (vga_rst_n === 1'b1 && n < int'(N) + 10) begin step(); n++; end
      total++; if (n != int'(N + 1)) begin bad++; $display("FAIL loss_latency: got %0d expected %0d", n, N + 1); end
      total++; if (state !== 3'd0 || pll_rst !== 1'b1 || retry_cnt !== '0) begin
        bad++; $display("FAIL loss_state: got state=%0d pll_rst=%0b retry=%0d expected 0/1/0", state, pll_rst, retry_cnt);
      end
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
`ifdef VGA_PLL_LOSS_CNT_EN
      total++; if (loss_cnt !== 8'(exp_loss)) begin bad++; $display("FAIL loss_cnt: got %0d expected %0d", loss_cnt, exp_loss); end
`endif
      test_lock_sequence($urandom_range(0, 120));
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (state !== 3'd0 || pll_rst !== 1'b1 || vga_rst_n !== 1'b0 || fail !== 1'b0 || retry_cnt !== '0) begin
      bad++; $display("FAIL async_reset: got state=%0d pll_rst=%0b vga=%0b fail=%0b retry=%0d expected 0/1/0/0/0", state, pll_rst, vga_rst_n, fail, retry_cnt);
    end
`ifdef VGA_PLL_LOSS_CNT_EN
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL async_loss: got %0d expected 0", loss_cnt); end
`endif
    pll_locked = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    exp_loss = 0;
    test_lock_sequence($urandom_range(0, 120));
  endtask

  initial begin
    test_reset();
    test_lock_sequence(100);
    test_timeout_fail();
    test_restart();
    test_glitch();
    test_lock_loss(3);
    test_async_reset();
    test_lock_loss(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
